// File: rtl/onehot_demux_fifo.sv
// One valid/ready input stream demultiplexed by a one-hot select into six independent FIFOs.
// Optional macro ONEHOT_DEMUX_SEL_CHECK_EN: illegal selects are dropped and flagged on sel_err.
module onehot_demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [5:0]       out_valid,
  input  logic [5:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [WIDTH-1:0] out_data4,
  output logic [WIDTH-1:0] out_data5,
  output logic             sel_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic       w_legal;
  logic [5:0] w_route;
  logic [5:0] w_full;

  assign w_legal = (in_sel != 6'b0) && ((in_sel & (in_sel - 6'd1)) == 6'b0);

`ifdef ONEHOT_DEMUX_SEL_CHECK_EN
  logic r_sel_err;

  // Illegal selects are swallowed: ready high, no channel written.
  assign w_route  = w_legal ? in_sel : 6'b0;
  assign in_ready = w_legal ? |(in_sel & ~w_full) : 1'b1;
  assign sel_err  = r_sel_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sel_err <= 1'b0;
    else          r_sel_err <= in_valid & ~w_legal;
  end
`else
  // Illegal selects fall through to channel 0, like the mux default arm.
  assign w_route  = w_legal ? in_sel : 6'b000001;
  assign in_ready = |(w_route & ~w_full);
  assign sel_err  = 1'b0;
`endif

  for (genvar k = 0; k < 6; k++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_out;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_head_idx;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;

    assign w_valid      = (r_count != '0);
    assign out_valid[k] = w_valid;
    assign w_full[k]    = (r_count == CW'(DEPTH));
    assign w_push       = in_valid & in_ready & w_route[k];
    assign w_pop        = out_ready[k] & w_valid;
    assign w_head_idx   = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

    always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
      else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    // r_out is the registered head; when the next head is the beat being written
    // this cycle it is taken straight from in_data. It holds when the FIFO empties.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_out    <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_count_nxt != '0)
          r_out <= (w_push && (w_head_idx == r_wr_ptr)) ? in_data : r_mem[w_head_idx];
      end
    end
  end

  assign out_data0 = g_ch[0].r_out;
  assign out_data1 = g_ch[1].r_out;
  assign out_data2 = g_ch[2].r_out;
  assign out_data3 = g_ch[3].r_out;
  assign out_data4 = g_ch[4].r_out;
  assign out_data5 = g_ch[5].r_out;

endmodule

// File: tb/tb_onehot_demux_fifo.sv
// Scoreboard bench for onehot_demux_fifo: per-channel expected queues checked every cycle.
module tb_onehot_demux_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [5:0]       out_valid;
  logic [5:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3, out_data4, out_data5;
  logic             sel_err;

  onehot_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
    .out_data3(out_data3), .out_data4(out_data4), .out_data5(out_data5),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] w_od [6];
  assign w_od[0] = out_data0;
  assign w_od[1] = out_data1;
  assign w_od[2] = out_data2;
  assign w_od[3] = out_data3;
  assign w_od[4] = out_data4;
  assign w_od[5] = out_data5;

  logic [WIDTH-1:0] sb_q [6][$];
  logic [WIDTH-1:0] sb_last [6];
  logic             exp_err;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("out_valid[%0d]", k), {31'b0, out_valid[k]}, {31'b0, sb_q[k].size() != 0});
      if (sb_q[k].size() != 0) check($sformatf("out_data%0d", k), w_od[k], sb_q[k][0]);
      else                     check($sformatf("out_data%0d_hold", k), w_od[k], sb_last[k]);
    end
  endtask

  // Drive one cycle of stimulus, check pre-edge outputs, then update the scoreboard.
  task automatic step(input logic v, input logic [5:0] sel, input logic [WIDTH-1:0] d,
                      input logic [5:0] rdy);
    logic legal, exp_rdy, do_push;
    int   ch;
    @(negedge clk);
    in_valid = v; in_sel = sel; in_data = d; out_ready = rdy;
    #1;
    legal = $onehot(sel);
    ch = 0;
    for (int k = 0; k < 6; k++) if (sel[k]) ch = k;
    if (legal) begin
      exp_rdy = (sb_q[ch].size() < DEPTH);
      do_push = v && exp_rdy;
    end else begin
`ifdef ONEHOT_DEMUX_SEL_CHECK_EN
      exp_rdy = 1'b1;
      do_push = 1'b0;
`else
      ch = 0;
      exp_rdy = (sb_q[0].size() < DEPTH);
      do_push = v && exp_rdy;
`endif
    end
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    check("sel_err", {31'b0, sel_err}, {31'b0, exp_err});
    check_outputs();
    @(posedge clk);
    for (int k = 0; k < 6; k++)
      if (rdy[k] && sb_q[k].size() != 0) sb_last[k] = sb_q[k].pop_front();
    if (do_push) sb_q[ch].push_back(d);
`ifdef ONEHOT_DEMUX_SEL_CHECK_EN
    exp_err = v && !legal;
`else
    exp_err = 1'b0;
`endif
  endtask

  task automatic clear_model();
    for (int k = 0; k < 6; k++) begin
      sb_q[k].delete();
      sb_last[k] = '0;
    end
    exp_err = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_reset_sel_err", {31'b0, sel_err}, 32'd0);
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Single route to channel 2, pop, then hold.
    step(1'b1, 6'b000100, 32'hDEAD_BEEF, 6'b000000);
    step(1'b0, 6'b000000, 32'h0,         6'b000100);
    step(1'b0, 6'b000000, 32'h0,         6'b000000);

    // Fill/backpressure on channel 5.
    step(1'b1, 6'b100000, 32'd1, 6'b000000);
    step(1'b1, 6'b100000, 32'd2, 6'b000000);
    step(1'b1, 6'b100000, 32'd3, 6'b000000);
    step(1'b1, 6'b100000, 32'd3, 6'b100000);
    step(1'b1, 6'b100000, 32'd3, 6'b100000);
    step(1'b0, 6'b100000, 32'd0, 6'b100000);
    step(1'b0, 6'b000000, 32'd0, 6'b000000);

    // Simultaneous push/pop at count 1 on channel 0.
    step(1'b1, 6'b000001, 32'h11, 6'b000000);
    step(1'b1, 6'b000001, 32'h22, 6'b000001);
    step(1'b0, 6'b000000, 32'h0,  6'b000001);

    // Channel 1 full and stalled while channel 3 streams.
    step(1'b1, 6'b000010, 32'hA1, 6'b000000);
    step(1'b1, 6'b000010, 32'hA2, 6'b000000);
    for (int i = 0; i < 10; i++) step(1'b1, 6'b001000, 32'h300 + i, 6'b001000);
    step(1'b0, 6'b000000, 32'h0, 6'b001000);
    step(1'b0, 6'b000000, 32'h0, 6'b000010);
    step(1'b0, 6'b000000, 32'h0, 6'b000010);

    // Illegal multi-hot and zero selects.
    step(1'b1, 6'b000011, 32'h5, 6'b000000);
    step(1'b0, 6'b000000, 32'h0, 6'b000000);
    step(1'b1, 6'b000000, 32'h6, 6'b000001);
    step(1'b0, 6'b000000, 32'h0, 6'b000001);
    step(1'b0, 6'b000000, 32'h0, 6'b000000);

    // Reset mid-operation with two entries in channels 0 and 4.
    step(1'b1, 6'b000001, 32'hC0, 6'b000000);
    step(1'b1, 6'b000001, 32'hC1, 6'b000000);
    step(1'b1, 6'b010000, 32'hE0, 6'b000000);
    step(1'b1, 6'b010000, 32'hE1, 6'b000000);
    @(negedge clk);
    in_valid = 1'b0; out_ready = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_out_valid", {26'b0, out_valid}, 32'd0);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 6'b000000, 32'h0, 6'b111111);

    // Random traffic, mostly legal selects.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] s;
      if ($urandom_range(0, 9) == 0) s = 6'($urandom);
      else s = 6'b1 << $urandom_range(0, 5);
      step(1'($urandom), s, $urandom, 6'($urandom));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 6'b0, 32'h0, 6'b111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
